// File: rtl/axis_downsizer.sv
// AXI4-Stream width down-converter: each wide beat leaves as RATIO narrow beats, lowest segment first.
// Latency: first narrow beat is valid the cycle after the wide beat is accepted; one narrow beat per cycle.
// Backpressure: the wide beat is held until its final segment handshakes; on a tlast beat, trailing empty segments are trimmed.
module axis_downsizer #(
  parameter int M_DATA_WIDTH = 8,
  parameter int RATIO        = 4,
  parameter int USER_WIDTH   = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [M_DATA_WIDTH*RATIO-1:0]         s_axis_tdata,
  input  logic [(M_DATA_WIDTH/8)*RATIO-1:0]     s_axis_tkeep,
  input  logic                                  s_axis_tvalid,
  output logic                                  s_axis_tready,
  input  logic                                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0]                 s_axis_tuser,
  output logic [M_DATA_WIDTH-1:0]               m_axis_tdata,
  output logic [M_DATA_WIDTH/8-1:0]             m_axis_tkeep,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic                                  m_axis_tlast,
  output logic [USER_WIDTH-1:0]                 m_axis_tuser
);

  localparam int S_DATA_WIDTH = M_DATA_WIDTH * RATIO;
  localparam int M_KEEP_WIDTH = M_DATA_WIDTH / 8;
  localparam int S_KEEP_WIDTH = M_KEEP_WIDTH * RATIO;
  localparam int SEG_W        = (RATIO > 2) ? $clog2(RATIO) : 1;

  typedef enum logic {EMPTY = 1'b0, BUSY = 1'b1} state_t;

  state_t                  state;
  logic [S_DATA_WIDTH-1:0] data_q;
  logic [S_KEEP_WIDTH-1:0] keep_q;
  logic                    last_q;
  logic [USER_WIDTH-1:0]   user_q;
  logic [SEG_W-1:0]        seg;
  logic [SEG_W-1:0]        last_seg;

  logic busy;
  logic at_last;
  logic s_hs;
  logic m_hs;

  // Final segment to emit: all segments for mid-packet beats, otherwise the
  // highest segment carrying any kept byte (segment 0 if nothing is kept).
  function automatic logic [SEG_W-1:0] calc_last_seg(input logic                    last,
                                                     input logic [S_KEEP_WIDTH-1:0] keep);
    logic [SEG_W-1:0] idx;
    idx = SEG_W'(RATIO - 1);
    if (last) begin
      idx = '0;
      for (int i = 0; i < RATIO; i++) begin
        if (|keep[i*M_KEEP_WIDTH +: M_KEEP_WIDTH]) idx = SEG_W'(i);
      end
    end
    return idx;
  endfunction

  assign busy    = (state == BUSY);
  assign at_last = (seg == last_seg);

  // Ready while empty, or when the final segment leaves this cycle so the next
  // wide beat drops straight in without a bubble. Held low during reset.
  assign s_axis_tready = !rst && (!busy || (m_axis_tready && at_last));
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign m_hs          = busy && m_axis_tready;

  // Capture a wide beat, or step through its segments as the narrow side drains it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      seg      <= '0;
      last_seg <= '0;
      data_q   <= '0;
      keep_q   <= '0;
      last_q   <= 1'b0;
      user_q   <= '0;
    end else if (s_hs) begin
      state    <= BUSY;
      seg      <= '0;
      last_seg <= calc_last_seg(s_axis_tlast, s_axis_tkeep);
      data_q   <= s_axis_tdata;
      keep_q   <= s_axis_tkeep;
      last_q   <= s_axis_tlast;
      user_q   <= s_axis_tuser;
    end else if (m_hs) begin
      if (at_last) begin
        state <= EMPTY;
      end else begin
        seg <= seg + 1'b1;
      end
    end
  end

  // Select the current segment's data and keep out of the holding register.
  always_comb begin
    m_axis_tdata = '0;
    m_axis_tkeep = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (seg == SEG_W'(i)) begin
        m_axis_tdata = data_q[i*M_DATA_WIDTH +: M_DATA_WIDTH];
        m_axis_tkeep = keep_q[i*M_KEEP_WIDTH +: M_KEEP_WIDTH];
      end
    end
  end

  assign m_axis_tvalid = busy;
  assign m_axis_tlast  = busy && last_q && at_last;
  assign m_axis_tuser  = user_q;

endmodule

// File: tb/tb_axis_downsizer.sv
// Directed bench for axis_downsizer (M_DATA_WIDTH=8, RATIO=4) with a short
// randomized-backpressure section checked against a queue of expected narrow beats.
module tb_axis_downsizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_tdata  = '0;
  logic [3:0]  s_tkeep  = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast  = 1'b0;
  logic [0:0]  s_tuser  = '0;
  logic [7:0]  m_tdata;
  logic [0:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic [0:0]  m_tuser;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axis_downsizer #(
    .M_DATA_WIDTH(8),
    .RATIO(4),
    .USER_WIDTH(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_beat(input string tag, input logic [7:0] d, input logic k,
                             input logic l, input logic u, input logic sr);
    chk({tag, "_vld"},  32'(m_tvalid), 32'd1);
    chk({tag, "_dat"},  32'(m_tdata),  32'(d));
    chk({tag, "_keep"}, 32'(m_tkeep),  32'(k));
    chk({tag, "_last"}, 32'(m_tlast),  32'(l));
    chk({tag, "_user"}, 32'(m_tuser),  32'(u));
    chk({tag, "_srdy"}, 32'(s_tready), 32'(sr));
  endtask

  function automatic logic [31:0] mk(input int b);
    logic [7:0] base;
    base = 8'(8'h40 + 4 * b);
    return {base + 8'd3, base + 8'd2, base + 8'd1, base};
  endfunction

  logic [10:0] expq[$];
  logic [10:0] got;
  logic [10:0] e;
  logic [7:0]  prev_d;
  logic        prev_stall;
  logic        pending;
  int          sent;
  int          cyc;
  int          ls;

  initial begin
    m_tready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_vld",  32'(m_tvalid), 32'd0);
    chk("rst_dat",  32'(m_tdata),  32'd0);
    chk("rst_keep", 32'(m_tkeep),  32'd0);
    chk("rst_last", 32'(m_tlast),  32'd0);
    chk("rst_user", 32'(m_tuser),  32'd0);
    chk("rst_srdy", 32'(s_tready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_srdy", 32'(s_tready), 32'd1);

    // Full mid-packet beat: four segments, ready low until the last one
    s_tdata = 32'h44332211; s_tkeep = 4'hF; s_tlast = 1'b0; s_tuser = 1'b0; s_tvalid = 1'b1;
    @(negedge clk); s_tvalid = 1'b0; #1;
    expect_beat("t1_b0", 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1; expect_beat("t1_b1", 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1; expect_beat("t1_b2", 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1; expect_beat("t1_b3", 8'h44, 1'b1, 1'b0, 1'b0, 1'b1);

    // Trimmed last beat (keep=0x3), accepted as 0x44 handshakes
    s_tdata = 32'hDDCCBBAA; s_tkeep = 4'h3; s_tlast = 1'b1; s_tvalid = 1'b1;
    @(negedge clk); s_tvalid = 1'b0; #1;
    expect_beat("t2_b0", 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1; expect_beat("t2_b1", 8'hBB, 1'b1, 1'b1, 1'b0, 1'b1);

    // All-zero keep on a last beat: one beat with keep 0 and tlast
    s_tdata = 32'h12345678; s_tkeep = 4'h0; s_tlast = 1'b1; s_tuser = 1'b1; s_tvalid = 1'b1;
    @(negedge clk); s_tvalid = 1'b0; #1;
    expect_beat("t3", 8'h78, 1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge clk); #1;
    chk("t3_idle_vld", 32'(m_tvalid), 32'd0);
    s_tuser = 1'b0;

    // Back-to-back wide beats: 16 contiguous narrow beats
    s_tdata = mk(0); s_tkeep = 4'hF; s_tlast = 1'b0; s_tvalid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); #1;
      chk($sformatf("t4_vld%0d", k),  32'(m_tvalid), 32'd1);
      chk($sformatf("t4_dat%0d", k),  32'(m_tdata),  32'(8'h40 + k));
      chk($sformatf("t4_srdy%0d", k), 32'(s_tready), 32'((k % 4) == 3));
      if ((k % 4) == 3) begin
        if (k < 15) s_tdata = mk(k / 4 + 1);
        else        s_tvalid = 1'b0;
      end
    end
    @(negedge clk); #1;
    chk("t4_idle_vld", 32'(m_tvalid), 32'd0);

    // Directed stalls: outputs hold while m_tready is low
    s_tdata = 32'h8C8B8A89; s_tkeep = 4'hF; s_tlast = 1'b1; s_tvalid = 1'b1; m_tready = 1'b0;
    @(negedge clk); s_tvalid = 1'b0; #1;
    expect_beat("t5_s0", 8'h89, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1; expect_beat("t5_s0h", 8'h89, 1'b1, 1'b0, 1'b0, 1'b0);
    m_tready = 1'b1; #1;
    @(negedge clk); #1; expect_beat("t5_s1", 8'h8A, 1'b1, 1'b0, 1'b0, 1'b0);
    m_tready = 1'b0;
    @(negedge clk); #1; expect_beat("t5_s1h", 8'h8A, 1'b1, 1'b0, 1'b0, 1'b0);
    m_tready = 1'b1;
    @(negedge clk); #1; expect_beat("t5_s2", 8'h8B, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1; expect_beat("t5_s3", 8'h8C, 1'b1, 1'b1, 1'b0, 1'b1);

    // Last beat with a hole at segment 0 and an empty top segment
    s_tdata = 32'h5D5C5B5A; s_tkeep = 4'b0110; s_tlast = 1'b1; s_tvalid = 1'b1;
    @(negedge clk); #1;
    expect_beat("t5_p0", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    s_tdata = 32'h6D6C6B6A; s_tkeep = 4'b0101; s_tlast = 1'b0;
    @(negedge clk); #1; expect_beat("t5_p1", 8'h5B, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1; expect_beat("t5_p2", 8'h5C, 1'b1, 1'b1, 1'b0, 1'b1);
    // Mid-packet beat with sparse keep: all four segments pass keep through
    @(negedge clk); s_tvalid = 1'b0; #1;
    expect_beat("t5_q0", 8'h6A, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1; expect_beat("t5_q1", 8'h6B, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1; expect_beat("t5_q2", 8'h6C, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1; expect_beat("t5_q3", 8'h6D, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); #1;
    chk("t5_idle_vld", 32'(m_tvalid), 32'd0);

    // Random backpressure and input gaps against an expected-beat queue
    sent = 0; cyc = 0; pending = 1'b0; prev_stall = 1'b0; prev_d = '0;
    while ((sent < 200 || expq.size() != 0 || s_tvalid) && cyc < 5000) begin
      if ((!s_tvalid || pending) && sent < 200) begin
        s_tvalid = ($urandom_range(0, 3) != 0);
        s_tdata  = $urandom;
        s_tkeep  = 4'($urandom_range(0, 15));
        s_tlast  = 1'($urandom_range(0, 1));
        s_tuser  = 1'($urandom_range(0, 1));
      end else if (pending) begin
        s_tvalid = 1'b0;
      end
      pending  = 1'b0;
      m_tready = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) chk("rnd_stall_hold", 32'(m_tdata), 32'(prev_d));
      if (m_tvalid && m_tready) begin
        got = {m_tuser, m_tlast, m_tkeep, m_tdata};
        if (expq.size() == 0) begin
          chk("rnd_extra_beat", 32'(expq.size()), 32'd1);
        end else begin
          e = expq.pop_front();
          chk("rnd_beat", 32'(got), 32'(e));
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_d     = m_tdata;
      if (s_tvalid && s_tready) begin
        ls = 3;
        if (s_tlast) begin
          ls = 0;
          for (int i = 0; i < 4; i++) if (s_tkeep[i]) ls = i;
        end
        for (int i = 0; i <= ls; i++)
          expq.push_back({s_tuser, s_tlast && (i == ls), s_tkeep[i], s_tdata[i*8 +: 8]});
        sent++;
        pending = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    chk("rnd_no_timeout", 32'(cyc < 5000), 32'd1);
    chk("rnd_drained", 32'(expq.size()), 32'd0);
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; m_tready = 1'b1;
    @(negedge clk); #1;
    chk("rnd_idle_vld", 32'(m_tvalid), 32'd0);

    // Asynchronous reset mid-burst discards the partially emitted beat
    s_tdata = 32'h44332211; s_tkeep = 4'hF; s_tlast = 1'b0; s_tvalid = 1'b1;
    @(negedge clk); s_tvalid = 1'b0; #1;
    expect_beat("t6_b0", 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1; expect_beat("t6_b1", 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1; expect_beat("t6_b2", 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    #1; rst = 1'b1; #1;
    chk("t6_rst_vld",  32'(m_tvalid), 32'd0);
    chk("t6_rst_dat",  32'(m_tdata),  32'd0);
    chk("t6_rst_last", 32'(m_tlast),  32'd0);
    chk("t6_rst_srdy", 32'(s_tready), 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("t6_rel_srdy", 32'(s_tready), 32'd1);
    chk("t6_rel_vld",  32'(m_tvalid), 32'd0);
    s_tdata = 32'h08070605; s_tkeep = 4'hF; s_tlast = 1'b0; s_tvalid = 1'b1;
    @(negedge clk); s_tvalid = 1'b0; #1;
    expect_beat("t6_n0", 8'h05, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1; expect_beat("t6_n1", 8'h06, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1; expect_beat("t6_n2", 8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1; expect_beat("t6_n3", 8'h08, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk); #1;
    chk("t6_idle_vld", 32'(m_tvalid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
